// File: rtl/walk_signal_arbiter_pkg.sv
// Shared types and elaboration-time helpers for the pedestrian walk-signal arbiter.
package walk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WALK  = 2'd1,
        CLEAR = 2'd2
    } walk_state_t;

    // Bits needed to hold values 0..v-1, never less than one bit.
    function automatic int clog2_min1(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int cnt_width(input int walk_len, input int clear_len);
        return clog2_min1(max_int(walk_len, clear_len));
    endfunction

endpackage

// File: rtl/walk_signal_arbiter_rr_pick.sv
// Combinational round-robin picker: first set candidate after last_grant, wrapping modulo N_CH.
module rr_pick #(
    parameter int N_CH  = 2,
    parameter int IDX_W = 1
) (
    input  logic [N_CH-1:0]  cand,
    input  logic [IDX_W-1:0] last_grant,
    output logic [N_CH-1:0]  grant,
    output logic [IDX_W-1:0] grant_idx
);

    int               idx;
    logic [IDX_W-1:0] pos;
    logic             found;

    // Offsets 1..N_CH visit every channel once, last_grant itself last.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        pos       = '0;
        for (int off = 1; off <= N_CH; off++) begin
            idx = int'(last_grant) + off;
            if (idx >= N_CH) begin
                idx = idx - N_CH;
            end
            pos = IDX_W'(idx);
            if (!found && cand[pos]) begin
                found      = 1'b1;
                grant[pos] = 1'b1;
                grant_idx  = pos;
            end
        end
    end

endmodule

// File: rtl/walk_signal_arbiter.sv
// N-channel pedestrian walk controller: latches requests, grants one channel at a time
// through timed WALK then CLEAR phases, serving contenders round-robin.
module walk_signal_arbiter
    import walk_pkg::*;
#(
    parameter int N_CH         = 2,
    parameter int WALK_CYCLES  = 8,
    parameter int CLEAR_CYCLES = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] req,
    output logic [N_CH-1:0] walk,
    output logic [N_CH-1:0] clear,
    output logic [N_CH-1:0] pending,
    output logic            busy
);

    localparam int CNT_W = cnt_width(WALK_CYCLES, CLEAR_CYCLES);
    localparam int IDX_W = clog2_min1(N_CH);

    localparam logic [CNT_W-1:0] WALK_LOAD  = CNT_W'(WALK_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_RESET = IDX_W'(N_CH - 1);

    walk_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] last_grant;

    logic [N_CH-1:0]  cand;
    logic [N_CH-1:0]  pick;
    logic [IDX_W-1:0] pick_idx;
    logic             start_walk;
    logic [N_CH-1:0]  pending_next;

    assign cand = pending | req;

    rr_pick #(
        .N_CH (N_CH),
        .IDX_W(IDX_W)
    ) u_rr_pick (
        .cand      (cand),
        .last_grant(last_grant),
        .grant     (pick),
        .grant_idx (pick_idx)
    );

    // A new WALK starts from IDLE, or straight out of the last CLEAR cycle with no idle gap.
    always_comb begin
        start_walk = 1'b0;
        case (state)
            IDLE:    start_walk = |cand;
            CLEAR:   start_walk = (cnt == '0) && (|cand);
            default: start_walk = 1'b0;
        endcase
    end

    // The walk register is the one-hot of the channel currently in WALK, so it masks its own re-request.
    assign pending_next = (pending | (req & ~walk)) & ~(start_walk ? pick : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= LAST_RESET;
            walk       <= '0;
            clear      <= '0;
            pending    <= '0;
            busy       <= 1'b0;
        end else begin
            pending <= pending_next;
            if (start_walk) begin
                state      <= WALK;
                cnt        <= WALK_LOAD;
                walk       <= pick;
                clear      <= '0;
                last_grant <= pick_idx;
                busy       <= 1'b1;
            end else begin
                case (state)
                    WALK: begin
                        if (cnt == '0) begin
                            state <= CLEAR;
                            cnt   <= CLEAR_LOAD;
                            clear <= walk;
                            walk  <= '0;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    CLEAR: begin
                        if (cnt == '0) begin
                            state <= IDLE;
                            clear <= '0;
                            busy  <= 1'b0;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_walk_signal_arbiter.sv
// Bench for walk_signal_arbiter: a 2-channel and a 4-channel instance driven from vector tables
// through a scoreboard queue, plus a hand-written asynchronous mid-WALK reset check.
module tb_walk_signal_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n2;
    logic [1:0] req2, walk2, clear2, pending2;
    logic       busy2;

    logic       rst_n4;
    logic [3:0] req4, walk4, clear4, pending4;
    logic       busy4;

    walk_signal_arbiter #(
        .N_CH(2), .WALK_CYCLES(8), .CLEAR_CYCLES(4)
    ) dut2 (
        .clk(clk), .rst_n(rst_n2), .req(req2),
        .walk(walk2), .clear(clear2), .pending(pending2), .busy(busy2)
    );

    walk_signal_arbiter #(
        .N_CH(4), .WALK_CYCLES(8), .CLEAR_CYCLES(4)
    ) dut4 (
        .clk(clk), .rst_n(rst_n4), .req(req4),
        .walk(walk4), .clear(clear4), .pending(pending4), .busy(busy4)
    );

    typedef struct {
        logic       rst_n;
        logic [3:0] req;
        logic [3:0] walk;
        logic [3:0] clear;
        logic [3:0] pending;
        logic       busy;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   checkCount = 0;
    int   passCount  = 0;

    task automatic addRows(input int n, input logic rst, input logic [3:0] rq,
                           input logic [3:0] w, input logic [3:0] c,
                           input logic [3:0] p, input logic b);
        vec_t v;
        v.rst_n = rst; v.req = rq; v.walk = w; v.clear = c; v.pending = p; v.busy = b;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    task automatic compare(input string name, input logic [3:0] act, input logic [3:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
    endtask

    task automatic applyStimulus(input bit wide, input vec_t v);
        if (wide) begin
            rst_n4 = v.rst_n;
            req4   = v.req;
        end else begin
            rst_n2 = v.rst_n;
            req2   = v.req[1:0];
        end
        sb.push_back(v);
    endtask

    task automatic checkOutput(input bit wide);
        vec_t e;
        if (sb.size() == 0) begin
            checkCount++;
            $display("[TB] FAIL scoreboard_empty at %0t: got no entry, expected one", $time);
            return;
        end
        e = sb.pop_front();
        if (wide) begin
            compare("walk4",    walk4,    e.walk);
            compare("clear4",   clear4,   e.clear);
            compare("pending4", pending4, e.pending);
            compare("busy4",    {3'b0, busy4}, {3'b0, e.busy});
            compare("onehot4",  4'($countones(walk4 | clear4)), e.busy ? 4'd1 : 4'd0);
        end else begin
            compare("walk2",    {2'b0, walk2},    e.walk);
            compare("clear2",   {2'b0, clear2},   e.clear);
            compare("pending2", {2'b0, pending2}, e.pending);
            compare("busy2",    {3'b0, busy2},    {3'b0, e.busy});
        end
    endtask

    task automatic runTable(input bit wide);
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            applyStimulus(wide, vecs[i]);
            @(posedge clk);
            #1;
            checkOutput(wide);
        end
        vecs.delete();
    endtask

    initial begin
        logic [3:0] oh;
        int         g;
        int         ph;

        rst_n2 = 1'b0; req2 = '0;
        rst_n4 = 1'b0; req4 = '0;

        // Reset held with all requests high, then release into a simultaneous 2'b11 request.
        addRows(3, 0, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 0);
        addRows(1, 1, 4'b0011, 4'b0001, 4'b0000, 4'b0010, 1);
        addRows(7, 1, 4'b0000, 4'b0001, 4'b0000, 4'b0010, 1);
        addRows(4, 1, 4'b0000, 4'b0000, 4'b0001, 4'b0010, 1);
        addRows(8, 1, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 1);
        addRows(4, 1, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 1);
        addRows(2, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
        // Single one-cycle pulse on channel 1.
        addRows(1, 1, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 1);
        addRows(7, 1, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 1);
        addRows(4, 1, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 1);
        addRows(2, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
        // Channel 0 re-requests during its own WALK (dropped) and its own CLEAR (served again).
        addRows(1, 1, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1);
        addRows(2, 1, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1);
        addRows(1, 1, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1);
        addRows(4, 1, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1);
        addRows(1, 1, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 1);
        addRows(1, 1, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 1);
        addRows(2, 1, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 1);
        addRows(8, 1, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1);
        addRows(4, 1, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 1);
        addRows(2, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
        // Grant channel 0 (last_grant becomes 0) and latch channel 1, up to WALK cycle 3.
        addRows(1, 1, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1);
        addRows(1, 1, 4'b0010, 4'b0001, 4'b0000, 4'b0010, 1);
        addRows(1, 1, 4'b0000, 4'b0001, 4'b0000, 4'b0010, 1);
        runTable(1'b0);

        // Asynchronous reset mid-WALK: outputs must drop before any clock edge.
        @(negedge clk);
        rst_n2 = 1'b0;
        #1;
        compare("async_walk",    {2'b0, walk2},    4'b0000);
        compare("async_clear",   {2'b0, clear2},   4'b0000);
        compare("async_pending", {2'b0, pending2}, 4'b0000);
        compare("async_busy",    {3'b0, busy2},    4'b0000);

        // After release, round-robin restarts so channel 0 wins against channel 1.
        addRows(1, 0, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 0);
        addRows(1, 1, 4'b0011, 4'b0001, 4'b0000, 4'b0010, 1);
        addRows(2, 1, 4'b0000, 4'b0001, 4'b0000, 4'b0010, 1);
        runTable(1'b0);

        // Fairness on 4 channels with every request held high: 0,1,2,3,0 each 12 cycles long.
        addRows(2, 0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 0);
        for (int k = 0; k < 60; k++) begin
            g  = (k / 12) % 4;
            ph = k % 12;
            oh = 4'(1 << g);
            if (ph < 8)       addRows(1, 1, 4'b1111, oh, 4'b0000, 4'b1111 & ~oh, 1);
            else if (ph == 8) addRows(1, 1, 4'b1111, 4'b0000, oh, 4'b1111 & ~oh, 1);
            else              addRows(1, 1, 4'b1111, 4'b0000, oh, 4'b1111, 1);
        end
        runTable(1'b1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
